svmr_wdata_fifo: RTL and testbench
==================================

// Module: svmr_wdata_fifo
// PURPOSE
//  - Matrix-register write-data buffer between the hpu_core MRA read port and the DDR write-data channel.
//  - Each captured word is a matrix-register row returned 4 clks after svmr_mra__re_o.
//  - Presents first-word-fall-through data to save_mtxreg_ctrl, which drives DDR wdata/vld/last from it.
//  - Raises a hysteretic programmable-full so the controller stops issuing reads while 4 words are in flight.
// PARAMETERS
//  DATA_WTH      512  word width (= DDRIF_DATA_WTH)
//  DEPTH_LOG2    5    log2 of depth; DEPTH = 32 entries
//  PFULL_ASSERT  24   occupancy at or above which mtxreg_data_full_o asserts
//  PFULL_NEGATE  20   occupancy at or below which mtxreg_data_full_o deasserts
//  Legal-parameter rules:
//   - PFULL_NEGATE < PFULL_ASSERT.
//   - DEPTH - PFULL_ASSERT >= 5, giving 4 clks of MRA read latency plus 1 clk of flag registration.
// PORTS
//  clk_i                 in   1              clock
//  rst_i                 in   1              synchronous reset, active-high
//  mtxreg_data_we_i      in   1              write strobe (delayed svmr_mra__re_o)
//  mtxreg_data_i         in   DATA_WTH       matrix-register read data
//  mtxreg_data_re_i      in   1              pop strobe (!empty && ddr wdata_rdy)
//  mtxreg_data_o         out  DATA_WTH       head word, valid while empty_o==0
//  mtxreg_data_full_o    out  1              programmable full, registered, hysteretic
//  mtxreg_data_empty_o   out  1              registered empty
//  mtxreg_data_cnt_o     out  DEPTH_LOG2+1   occupancy, 0..DEPTH
//  mtxreg_data_ovf_o     out  1              sticky overflow (see CONFIGURATION)
//  mtxreg_data_udf_o     out  1              sticky underflow (see CONFIGURATION)
//  mtxreg_err_clr_i      in   1              clears ovf/udf
// BEHAVIOUR
//  Reset values:
//   - Read/write pointers = 0; cnt = 0.
//   - empty = 1; full = 0; ovf = udf = 0.
//   - mtxreg_data_o = 0.
//   - Storage contents are not reset.
//  Storage and pointers:
//   - Circular array of DEPTH entries; wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo DEPTH.
//   - cnt is DEPTH_LOG2+1 bits.
//  Write:
//   - Accepted when we_i=1 and (cnt<DEPTH or a pop is accepted in the same clk).
//   - Otherwise the word is dropped and the overflow event fires.
//  Pop:
//   - Accepted when re_i=1 and empty_o=0.
//   - re_i while empty_o=1 is ignored and fires the underflow event.
//  FWFT and empty:
//   - mtxreg_data_o always equals the entry at rd_ptr.
//   - After a write into an empty FIFO, empty_o deasserts 1 clk later (write clk N, data valid clk N+1).
//   - After a pop, the next word appears the following clk.
//   - empty_o asserts in the clk after the last word is popped.
//   - A write and pop in the same clk when cnt==1: empty_o stays 0.
//  Simultaneous write and pop:
//   - Both are accepted; cnt is unchanged.
//   - This holds at cnt==DEPTH as well, so no overflow fires.
//   - At cnt==0 the pop is ignored and the write is accepted.
//  Programmable full:
//   - Registered. Sets when next-cnt >= PFULL_ASSERT; clears when next-cnt <= PFULL_NEGATE.
//   - Holds its value in between.
//   - Visible 1 clk after the causing write or pop.
//  Data ordering:
//   - Strictly in order.
//   - No data is lost while the writer honours full_o with at most 4 in-flight words.
//  Reset mid-operation:
//   - All contents are discarded and all outputs return to their reset values next clk.
//   - we_i and re_i asserted in the reset clk are ignored and raise no error flag.
// CONFIGURATION
//  Macro: SVMR_WDATA_FIFO_ERR_EN.
//  Defined:
//   - ovf_o sets on an overflow event; udf_o sets on an underflow event.
//   - Both are sticky until err_clr_i or reset.
//   - If err_clr_i and an event occur in the same clk, the flag is set.
//  Undefined:
//   - ovf_o and udf_o are tied 0; err_clr_i is unused.
//   - FIFO data behaviour is identical.
// TESTING
//  1. Reset, write 0xA0..0xA3 on 4 back-to-back clks -> empty_o drops 1 clk after the first write; data_o=0xA0; pops return A0,A1,A2,A3; empty_o=1 after the 4th pop.
//  2. Write 24 words with no pops -> full_o=1 on the clk after the 24th write, cnt=24; pop 3 -> full_o stays 1; pop 1 more (cnt=20) -> full_o=0 next clk.
//  3. Stop writes at full_o rise, then deliver 4 more in-flight writes -> cnt=28; all 28 words drain in order; ovf_o=0.
//  4. Fill to 32, then one clk with we_i=1 and re_i=1 -> cnt stays 32, ovf_o=0; next clk we_i only -> word dropped, cnt=32, ovf_o=1 (macro on) / 0 (macro off); err_clr_i -> ovf_o=0.
//  5. re_i pulse while empty -> cnt=0, data unchanged, udf_o=1 (macro on).
//  6. At cnt=10 with full_o=0, assert rst_i for 1 clk with we_i=1 -> next clk cnt=0, empty_o=1, full_o=0, ovf_o=udf_o=0.

Source files
------------

// File: rtl/svmr_wdata_fifo.sv
// Matrix-register write-data FIFO between the MRA read port and the DDR write-data channel.
// Latency: a write is visible on the head/empty/cnt outputs 1 clk later; pops advance the head next clk.
// Backpressure: hysteretic programmable full (registered) throttles reads; writes at cnt==DEPTH are dropped.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mtxreg_data_we_i/_i     write strobe and row data from the MRA read port
//   mtxreg_data_re_i        pop strobe from save_mtxreg_ctrl
//   mtxreg_data_o           FWFT head word (valid while empty_o==0)
//   mtxreg_data_full_o      programmable full, registered
//   mtxreg_data_empty_o     registered empty
//   mtxreg_data_cnt_o       occupancy 0..DEPTH
//   mtxreg_data_ovf_o/udf_o sticky error flags
//   mtxreg_err_clr_i        clears the sticky error flags
// Optional feature macro: SVMR_WDATA_FIFO_ERR_EN enables the sticky ovf/udf flags;
// when undefined both flags are tied 0 and err_clr_i is unused.
module svmr_wdata_fifo #(
    parameter int DATA_WTH     = 512,
    parameter int DEPTH_LOG2   = 5,
    parameter int PFULL_ASSERT = 24,
    parameter int PFULL_NEGATE = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mtxreg_data_we_i,
    input  logic [DATA_WTH-1:0]   mtxreg_data_i,
    input  logic                  mtxreg_data_re_i,
    output logic [DATA_WTH-1:0]   mtxreg_data_o,
    output logic                  mtxreg_data_full_o,
    output logic                  mtxreg_data_empty_o,
    output logic [DEPTH_LOG2:0]   mtxreg_data_cnt_o,
    output logic                  mtxreg_data_ovf_o,
    output logic                  mtxreg_data_udf_o,
    input  logic                  mtxreg_err_clr_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_PFA   = (DEPTH_LOG2+1)'(PFULL_ASSERT);
    localparam logic [DEPTH_LOG2:0]   CNT_PFN   = (DEPTH_LOG2+1)'(PFULL_NEGATE);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [DATA_WTH-1:0]   mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic [DATA_WTH-1:0]   data_q, data_d;

    logic pop_acc;
    logic wr_acc;
    logic ovf_evt;
    logic udf_evt;

    // Reset wins over everything: strobes in the reset clk are neither
    // accepted nor reported as errors.
    always_comb begin
        pop_acc = !rst_i && mtxreg_data_re_i && !empty_q;
        // A pop in the same clk frees a slot, so a write at cnt==DEPTH still lands.
        wr_acc  = !rst_i && mtxreg_data_we_i && ((cnt_q < CNT_DEPTH) || pop_acc);
        ovf_evt = !rst_i && mtxreg_data_we_i && !wr_acc;
        udf_evt = !rst_i && mtxreg_data_re_i && empty_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_acc && !pop_acc) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!wr_acc && pop_acc) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        empty_d = (cnt_d == '0);

        // Hysteresis: hold between the negate and assert thresholds.
        full_d = full_q;
        if (cnt_d >= CNT_PFA) begin
            full_d = 1'b1;
        end else if (cnt_d <= CNT_PFN) begin
            full_d = 1'b0;
        end

        // Registered head: the word at the next rd_ptr, bypassing the array
        // when that slot is the one being written this clk (write into empty,
        // or write+pop at cnt==1).
        if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
            data_d = mtxreg_data_i;
        end else begin
            data_d = mem[rd_ptr_d];
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= mtxreg_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            data_q   <= data_d;
        end
    end

`ifdef SVMR_WDATA_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // An event in the same clk as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_evt || (ovf_q && !mtxreg_err_clr_i);
        udf_d = udf_evt || (udf_q && !mtxreg_err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign mtxreg_data_ovf_o = ovf_q;
    assign mtxreg_data_udf_o = udf_q;
`else
    logic unused_err;
    assign unused_err        = mtxreg_err_clr_i ^ ovf_evt ^ udf_evt;
    assign mtxreg_data_ovf_o = 1'b0;
    assign mtxreg_data_udf_o = 1'b0;
`endif

    assign mtxreg_data_o       = data_q;
    assign mtxreg_data_full_o  = full_q;
    assign mtxreg_data_empty_o = empty_q;
    assign mtxreg_data_cnt_o   = cnt_q;

endmodule

// File: tb/tb_svmr_wdata_fifo.sv
// Self-checking bench for svmr_wdata_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model; every cycle all outputs are compared to the model.
module tb_svmr_wdata_fifo;

    localparam int DW    = 512;
    localparam int DEPTH = 32;
    localparam int PFA   = 24;
    localparam int PFN   = 20;
`ifdef SVMR_WDATA_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          we_i = 1'b0;
    logic [DW-1:0] din_i = '0;
    logic          re_i = 1'b0;
    logic          clr_i = 1'b0;
    logic [DW-1:0] dout_o;
    logic          full_o, empty_o, ovf_o, udf_o;
    logic [5:0]    cnt_o;

    always #5 clk = ~clk;

    svmr_wdata_fifo dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .mtxreg_data_we_i    (we_i),
        .mtxreg_data_i       (din_i),
        .mtxreg_data_re_i    (re_i),
        .mtxreg_data_o       (dout_o),
        .mtxreg_data_full_o  (full_o),
        .mtxreg_data_empty_o (empty_o),
        .mtxreg_data_cnt_o   (cnt_o),
        .mtxreg_data_ovf_o   (ovf_o),
        .mtxreg_data_udf_o   (udf_o),
        .mtxreg_err_clr_i    (clr_i)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: occupancy is the queue, flags follow the stated rules.
    logic [DW-1:0] mq[$];
    bit            m_full = 1'b0;
    bit            m_ovf  = 1'b0;
    bit            m_udf  = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit we, input logic [DW-1:0] d, input bit re,
                              input bit clr, input bit rst);
        bit pop, push, oe, ue;
        int n;
        if (rst) begin
            mq.delete();
            m_full = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            n    = mq.size();
            pop  = re && (n > 0);
            push = we && ((n < DEPTH) || pop);
            oe   = we && !push;
            ue   = re && (n == 0);
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(d);
            n = mq.size();
            if (n >= PFA)      m_full = 1'b1;
            else if (n <= PFN) m_full = 1'b0;
            if (ERR_EN) begin
                m_ovf = oe || (m_ovf && !clr);
                m_udf = ue || (m_udf && !clr);
            end
        end
    endtask

    // Full comparison of every DUT output against the model.
    task automatic compare_all();
        int n;
        n = mq.size();
        chk("cnt",   DW'(cnt_o),   DW'(n));
        chk("empty", DW'(empty_o), DW'(n == 0));
        chk("full",  DW'(full_o),  DW'(m_full));
        chk("ovf",   DW'(ovf_o),   DW'(m_ovf));
        chk("udf",   DW'(udf_o),   DW'(m_udf));
        if (n > 0) chk("head", dout_o, mq[0]);
    endtask

    // One clock: drive inputs away from the edge, advance model at the edge,
    // then sample DUT 1 time unit later.
    task automatic cyc(input bit we, input logic [DW-1:0] d, input bit re,
                       input bit clr, input bit rst);
        we_i  = we;
        din_i = d;
        re_i  = re;
        clr_i = clr;
        rst_i = rst;
        @(posedge clk);
        model_step(we, d, re, clr, rst);
        #1;
        compare_all();
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [DW-1:0] seq_word(input int k);
        return {16'hC0DE, 464'd0, 32'(k)};
    endfunction

    initial begin
        int wrote;
        int pr_we, pr_re;
        logic [DW-1:0] w;

        // Reset state
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 1);
        chk("rst_cnt",   DW'(cnt_o),   DW'(0));
        chk("rst_empty", DW'(empty_o), DW'(1));
        chk("rst_full",  DW'(full_o),  DW'(0));
        chk("rst_data",  dout_o,       DW'(0));

        // 1: four writes, FWFT, in-order pops
        cyc(1, DW'(8'hA0), 0, 0, 0);
        chk("t1_empty_drop", DW'(empty_o), DW'(0));
        chk("t1_head_a0",    dout_o,       DW'(8'hA0));
        cyc(1, DW'(8'hA1), 0, 0, 0);
        cyc(1, DW'(8'hA2), 0, 0, 0);
        cyc(1, DW'(8'hA3), 0, 0, 0);
        chk("t1_cnt4", DW'(cnt_o), DW'(4));
        for (int i = 0; i < 4; i++) begin
            chk("t1_pop_data", dout_o, DW'(8'hA0 + i));
            cyc(0, '0, 1, 0, 0);
        end
        chk("t1_empty_end", DW'(empty_o), DW'(1));

        // 2: full hysteresis
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 23; i++) cyc(1, seq_word(i), 0, 0, 0);
        chk("t2_full_pre", DW'(full_o), DW'(0));
        cyc(1, seq_word(23), 0, 0, 0);
        chk("t2_full_24", DW'(full_o), DW'(1));
        chk("t2_cnt_24",  DW'(cnt_o),  DW'(24));
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0);
        chk("t2_full_21", DW'(full_o), DW'(1));
        cyc(0, '0, 1, 0, 0);
        chk("t2_cnt_20",  DW'(cnt_o),  DW'(20));
        chk("t2_full_20", DW'(full_o), DW'(0));

        // 3: stop at full rise, then 4 in-flight writes, drain in order
        cyc(0, '0, 0, 0, 1);
        wrote = 0;
        while (full_o !== 1'b1 && wrote < 40) begin
            cyc(1, seq_word(100 + wrote), 0, 0, 0);
            wrote++;
        end
        chk("t3_full_after", DW'(wrote), DW'(24));
        for (int i = 0; i < 4; i++) begin
            cyc(1, seq_word(100 + wrote), 0, 0, 0);
            wrote++;
        end
        chk("t3_cnt_28", DW'(cnt_o), DW'(28));
        chk("t3_ovf",    DW'(ovf_o), DW'(0));

        // 4: fill to 32, write+pop at full depth, then overflow
        for (int i = 0; i < 4; i++) begin
            cyc(1, seq_word(100 + wrote), 0, 0, 0);
            wrote++;
        end
        chk("t4_cnt_32", DW'(cnt_o), DW'(32));
        cyc(1, seq_word(100 + wrote), 1, 0, 0);
        wrote++;
        chk("t4_wr_pop_cnt", DW'(cnt_o), DW'(32));
        chk("t4_wr_pop_ovf", DW'(ovf_o), DW'(0));
        cyc(1, DW'(16'hDEAD), 0, 0, 0);
        chk("t4_drop_cnt", DW'(cnt_o), DW'(32));
        chk("t4_drop_ovf", DW'(ovf_o), DW'(ERR_EN));
        cyc(0, '0, 0, 1, 0);
        chk("t4_clr_ovf", DW'(ovf_o), DW'(0));

        // Drain: head must be word #1 onward (word #0 popped in the write+pop clk)
        for (int i = 0; i < 32; i++) begin
            chk("t3_drain", dout_o, seq_word(101 + i));
            cyc(0, '0, 1, 0, 0);
        end

        // 5: underflow on empty pop
        cyc(0, '0, 1, 0, 0);
        chk("t5_cnt", DW'(cnt_o), DW'(0));
        chk("t5_udf", DW'(udf_o), DW'(ERR_EN));

        // 6: reset mid-operation with write asserted
        for (int i = 0; i < 10; i++) cyc(1, rnd_word(), 0, 0, 0);
        chk("t6_cnt_10", DW'(cnt_o), DW'(10));
        cyc(1, rnd_word(), 1, 0, 1);
        chk("t6_cnt",   DW'(cnt_o),   DW'(0));
        chk("t6_empty", DW'(empty_o), DW'(1));
        chk("t6_full",  DW'(full_o),  DW'(0));
        chk("t6_ovf",   DW'(ovf_o),   DW'(0));
        chk("t6_udf",   DW'(udf_o),   DW'(0));

        // Randomized traffic in phases of varying write/read pressure
        for (int p = 0; p < 20; p++) begin
            pr_we = $urandom_range(10, 95);
            pr_re = $urandom_range(10, 95);
            for (int c = 0; c < 150; c++) begin
                w = rnd_word();
                cyc(($urandom_range(0, 99) < pr_we),
                    w,
                    ($urandom_range(0, 99) < pr_re),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 399) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
